adder_pipelined: RTL and testbench

//  Parametrised, pipelined successor to the 4-bit ripple adder. Adds or subtracts two WIDTH-bit operands.
//  The carry chain is split into STAGES register-separated chunks; valid/ready handshakes sit on both sides.

---
 rtl/adder_pipelined_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 40 ++++
 rtl/adder_pipelined.sv | 130 +++++++++++++
 tb/tb_adder_pipelined.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipelined_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pipelined_pkg
//  Description : Shared constants and helpers for the pipelined adder slice.
//                Provides default width/depth and the carry-chunk width
//                derivation used by the top level.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pipelined_pkg;

   localparam int ADD_WIDTH_DEF  = 16;
   localparam int ADD_STAGES_DEF = 4;

   // Width of one carry chunk; the top level rejects non-integral splits.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : adder_chunk
//  Description : CW-bit ripple-carry adder slice built from full-adder cells.
//  Ports       : a, b   - chunk operands (CW bits)
//                ci     - carry into bit 0
//                s      - chunk sum (CW bits)
//                co     - carry out of the chunk MSB
//                c_msb  - carry into the chunk MSB (signed-overflow detection)
//  Revision    : 1.0  initial release
// ============================================================================
module adder_chunk #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          ci,
   output logic [CW-1:0] s,
   output logic          co,
   output logic          c_msb
);

   always_comb begin
      logic w_carry;
      s       = '0;
      c_msb   = 1'b0;
      w_carry = ci;
      for (int i = 0; i < CW; i++) begin
         if (i == CW - 1) begin
            c_msb = w_carry;
         end
         // Full-adder cell: sum and majority carry.
         s[i]    = a[i] ^ b[i] ^ w_carry;
         w_carry = (a[i] & b[i]) | (a[i] & w_carry) | (b[i] & w_carry);
      end
      co = w_carry;
   end

endmodule
`default_nettype wire

// File: rtl/adder_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pipelined
//  Description : Parametrised pipelined add/subtract unit. The carry chain is
//                cut into STAGES chunks of CW = WIDTH/STAGES bits, one chunk
//                resolved per pipeline stage. Valid/ready on both sides; the
//                whole pipe advances as one (no bubble collapse).
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid / in_ready  - operand handshake
//                A, B, Cin, Sub       - operands, carry-in, subtract mode
//                out_valid / out_ready- result handshake
//                Sum, Cout, Overflow  - result, carry out, signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module adder_pipelined
   import adder_pipelined_pkg::*;
#(
   parameter int WIDTH  = ADD_WIDTH_DEF,
   parameter int STAGES = ADD_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   generate
      if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
         $error("adder_pipelined: WIDTH must be a multiple of STAGES");
      end
   endgenerate

   logic              w_adv;
   logic [WIDTH-1:0]  w_b_eff;
   logic              w_cin0;
   logic [WIDTH-1:0]  w_cs;
   logic [STAGES-1:0] w_co;
   logic [STAGES-1:0] w_cm;
   logic              w_pipe_unused;

   logic [WIDTH-1:0]  r_a [STAGES];
   logic [WIDTH-1:0]  r_b [STAGES];
   logic [WIDTH-1:0]  r_s [STAGES];
   logic [STAGES-1:0] r_c;
   logic [STAGES-1:0] r_v;
   logic              r_cmsb;

   assign w_adv    = ~r_v[STAGES-1] | out_ready;
   assign in_ready = w_adv;

   // Subtract is folded in at entry (A + ~B + 1), so the mode travels with
   // the transaction as the pre-inverted B operand and the stage-0 carry.
   assign w_b_eff  = B ^ {WIDTH{Sub}};
   assign w_cin0   = Sub | Cin;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_chunk
         if (k == 0) begin : g_first
            adder_chunk #(.CW(CW)) u_chunk (
               .a     (A[CW-1:0]),
               .b     (w_b_eff[CW-1:0]),
               .ci    (w_cin0),
               .s     (w_cs[CW-1:0]),
               .co    (w_co[0]),
               .c_msb (w_cm[0])
            );
         end else begin : g_rest
            adder_chunk #(.CW(CW)) u_chunk (
               .a     (r_a[k-1][k*CW +: CW]),
               .b     (r_b[k-1][k*CW +: CW]),
               .ci    (r_c[k-1]),
               .s     (w_cs[k*CW +: CW]),
               .co    (w_co[k]),
               .c_msb (w_cm[k])
            );
         end
      end
   endgenerate

   // Last-stage operand copies and lower-chunk MSB carries have no reader.
   assign w_pipe_unused = ^{w_cm, r_a[STAGES-1], r_b[STAGES-1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
         r_c    <= '0;
         r_v    <= '0;
         r_cmsb <= 1'b0;
      end else if (w_adv) begin
         r_a[0]         <= A;
         r_b[0]         <= w_b_eff;
         r_s[0]         <= '0;
         r_s[0][CW-1:0] <= w_cs[CW-1:0];
         r_c[0]         <= w_co[0];
         r_v[0]         <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            r_a[k]              <= r_a[k-1];
            r_b[k]              <= r_b[k-1];
            r_s[k]              <= r_s[k-1];
            r_s[k][k*CW +: CW]  <= w_cs[k*CW +: CW];
            r_c[k]              <= w_co[k];
            r_v[k]              <= r_v[k-1];
         end
         // Carry into bit WIDTH-1 is only known in the final chunk's stage.
         r_cmsb <= w_cm[STAGES-1];
      end
   end

   assign out_valid = r_v[STAGES-1];
   assign Sum       = r_s[STAGES-1];
   assign Cout      = r_c[STAGES-1];
   assign Overflow  = r_c[STAGES-1] ^ r_cmsb;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_pipelined
//  Description : Self-checking bench for adder_pipelined. Main instance is
//                WIDTH=16/STAGES=4; a second WIDTH=8/STAGES=1 instance covers
//                the single-register configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_pipelined;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] A, B, Sum;
   logic        Cin, Sub, Cout, Overflow;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, sum8;
   logic        cin8, sub8, cout8, ovf8;

   int tests_run    = 0;
   int tests_failed = 0;

   adder_pipelined #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
   );

   adder_pipelined #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .Sum(sum8), .Cout(cout8), .Overflow(ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width sum, overflow from operand/result signs.
   function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
      logic [15:0] bb;
      logic [16:0] full;
      logic        ovf;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
      ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
      return {ovf, full[16], full[15:0]};
   endfunction

   // Issue one op on the 16-bit DUT and report latency and the result seen.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output int lat, output logic [15:0] s,
                         output logic co, output logic ov);
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
      lat = 0; s = '0; co = 1'b0; ov = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         if (out_valid) begin
            lat = n; s = Sum; co = Cout; ov = Overflow;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || Sum !== 16'h0000 || Cout !== 1'b0 || Overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b, want 0 0000 0 0",
                  out_valid, Sum, Cout, Overflow);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      tests_run++;
      if (out_valid8 !== 1'b0 || sum8 !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_dut8: got v=%b s=%h want 0 00", out_valid8, sum8);
      end
   endtask

   task automatic test_add;
      int lat; logic [15:0] s; logic co, ov;
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
      tests_run++;
      if (lat != 4) begin
         tests_failed++;
         $display("FAIL add_latency: got %0d want 4", lat);
      end
      tests_run++;
      if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL add_wrap: got s=%h c=%b o=%b want 0000 1 0", s, co, ov);
      end
      run_op(16'h1234, 16'h1111, 1'b1, 1'b0, lat, s, co, ov);
      tests_run++;
      if ({s, co, ov} !== {16'h2346, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL add_cin: got s=%h c=%b o=%b want 2346 0 0", s, co, ov);
      end
   endtask

   task automatic test_overflow;
      int lat; logic [15:0] s; logic co, ov;
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
      tests_run++;
      if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL ovf_pos: got s=%h c=%b o=%b want 8000 0 1", s, co, ov);
      end
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, s, co, ov);
      tests_run++;
      if ({s, co, ov} !== {16'h0000, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL ovf_neg: got s=%h c=%b o=%b want 0000 1 1", s, co, ov);
      end
   endtask

   task automatic test_sub;
      int lat; logic [15:0] s; logic co, ov;
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, s, co, ov);
      tests_run++;
      if ({s, co, ov} !== {16'hFFFE, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL sub_borrow: got s=%h c=%b o=%b want FFFE 0 0", s, co, ov);
      end
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, s, co, ov);
      tests_run++;
      if ({s, co, ov} !== {16'h0002, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL sub_noborrow: got s=%h c=%b o=%b want 0002 1 0", s, co, ov);
      end
   endtask

   task automatic test_back_to_back;
      logic [17:0] q_exp[$];
      logic [17:0] exp_v, prev_out;
      logic [15:0] ca, cb;
      logic        ccin, csub, prev_stall;
      int          sent, recv, cycles;
      sent = 0; recv = 0; cycles = 0; prev_stall = 1'b0; prev_out = '0;
      ca = 16'($urandom); cb = 16'($urandom); ccin = 1'($urandom); csub = 1'($urandom);
      @(posedge clk); #1;
      while (recv < 20 && cycles < 600) begin
         in_valid  = (sent < 20);
         A = ca; B = cb; Cin = ccin; Sub = csub;
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         tests_run++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            tests_failed++;
            $display("FAIL stream_in_ready: got %b with out_valid=%b out_ready=%b",
                     in_ready, out_valid, out_ready);
         end
         if (prev_stall) begin
            tests_run++;
            if (out_valid !== 1'b1 || {Overflow, Cout, Sum} !== prev_out) begin
               tests_failed++;
               $display("FAIL stream_hold: got v=%b %h want 1 %h",
                        out_valid, {Overflow, Cout, Sum}, prev_out);
            end
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (q_exp.size() == 0) begin
               tests_failed++;
               $display("FAIL stream_extra: got unexpected result %h want none", Sum);
            end else begin
               exp_v = q_exp.pop_front();
               if ({Overflow, Cout, Sum} !== exp_v) begin
                  tests_failed++;
                  $display("FAIL stream_result: got %h want %h (ovf,cout,sum)",
                           {Overflow, Cout, Sum}, exp_v);
               end
            end
            recv++;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {Overflow, Cout, Sum};
         if (in_valid && in_ready) begin
            q_exp.push_back(ref_add(ca, cb, ccin, csub));
            sent++;
            ca = 16'($urandom); cb = 16'($urandom); ccin = 1'($urandom); csub = 1'($urandom);
         end
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tests_run++;
      if (recv != 20) begin
         tests_failed++;
         $display("FAIL stream_timeout: got %0d results want 20", recv);
      end
   endtask

   task automatic test_reset_midstream;
      int lat, pulses; logic [15:0] s; logic co, ov;
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; Cin = 1'b0; Sub = 1'b0;
      A = 16'h1111; B = 16'h2222;
      @(posedge clk); #1;
      A = 16'h0100; B = 16'h0200;
      @(posedge clk); #1;
      A = 16'h4000; B = 16'h0004;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || Sum !== 16'h3333) begin
         tests_failed++;
         $display("FAIL midrst_pre: got v=%b s=%h want 1 3333", out_valid, Sum);
      end
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || Sum !== 16'h0000 || Cout !== 1'b0 || Overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_clear: got v=%b s=%h c=%b o=%b want 0 0000 0 0",
                  out_valid, Sum, Cout, Overflow);
      end
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      tests_run++;
      if (pulses != 0) begin
         tests_failed++;
         $display("FAIL midrst_stale: got %0d out_valid cycles want 0", pulses);
      end
      run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat, s, co, ov);
      tests_run++;
      if (lat != 4 || {s, co, ov} !== {16'h1000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL midrst_newop: got lat=%0d s=%h c=%b o=%b want 4 1000 0 0",
                  lat, s, co, ov);
      end
   endtask

   task automatic test_single_stage;
      int lat;
      lat = 0;
      @(posedge clk); #1;
      out_ready8 = 1'b1; in_valid8 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         @(posedge clk); #1;
         in_valid8 = 1'b0;
         @(negedge clk);
         if (out_valid8) begin
            lat = n;
            break;
         end
      end
      tests_run++;
      if (lat != 1) begin
         tests_failed++;
         $display("FAIL s1_latency: got %0d want 1", lat);
      end
      tests_run++;
      if ({sum8, cout8, ovf8} !== {8'hFF, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL s1_result: got s=%h c=%b o=%b want FF 1 0", sum8, cout8, ovf8);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      test_reset();
      test_add();
      test_overflow();
      test_sub();
      test_back_to_back();
      test_reset_midstream();
      test_single_stage();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
